// File: rtl/patch_collect_conv.sv
// Receive side of the conv patch address generator: aligns issued elements with
// IFM RAM read data, zero-fills padding and hands complete 3x3 patches to the MAC array.
module patch_collect_conv #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned BURST_SIZE  = 9,
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned NUM_PATCHES = 784
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              gen_enable,
    input  logic                              gen_valid,
    input  logic                              gen_zero_pad,
    input  logic                              gen_done,
    input  logic [DATA_WIDTH-1:0]             ram_rdata,
    output logic [BURST_SIZE*DATA_WIDTH-1:0]  patch_data,
    output logic [BURST_SIZE-1:0]             patch_pad_mask,
    output logic                              patch_valid,
    input  logic                              patch_ready,
    output logic [9:0]                        patch_idx,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              err_overflow
);

    localparam int unsigned CW = 4;
    localparam int unsigned IW = 10;
    localparam int unsigned PW = BURST_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] cap_cnt_q, cap_cnt_d;
    logic [IW-1:0] patch_idx_q, patch_idx_d;
    logic [PW-1:0] data_q, data_d;
    logic [BURST_SIZE-1:0] mask_q, mask_d;
    logic err_q, err_d;
    logic frame_done_q, frame_done_d;
    logic gen_enable_q, gen_enable_d;
    logic patch_valid_q, patch_valid_d;
    logic busy_q, busy_d;

    // Tag pipeline: entry RAM_LATENCY-1 lines up with ram_rdata for its element
    logic [RAM_LATENCY-1:0]         tv_q, tv_d;
    logic [RAM_LATENCY-1:0]         tp_q, tp_d;
    logic [RAM_LATENCY-1:0][CW-1:0] ti_q, ti_d;

    logic push;
    logic head_v;
    logic head_p;
    logic [CW-1:0] head_i;

    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        cap_cnt_d     = cap_cnt_q;
        patch_idx_d   = patch_idx_q;
        data_d        = data_q;
        mask_d        = mask_q;
        err_d         = err_q;
        frame_done_d  = 1'b0;
        tv_d          = tv_q;
        tp_d          = tp_q;
        ti_d          = ti_q;

        head_v = tv_q[RAM_LATENCY-1];
        head_p = tp_q[RAM_LATENCY-1];
        head_i = ti_q[RAM_LATENCY-1];
        push   = (state_q == S_COLLECT) && gen_valid && (issue_cnt_q < CW'(BURST_SIZE));

        for (int i = RAM_LATENCY - 1; i > 0; i--) begin
            tv_d[i] = tv_q[i-1];
            tp_d[i] = tp_q[i-1];
            ti_d[i] = ti_q[i-1];
        end
        tv_d[0] = push;
        tp_d[0] = gen_zero_pad;
        ti_d[0] = issue_cnt_q;

        if (push) begin
            issue_cnt_d = issue_cnt_q + CW'(1);
        end

        // Capture is independent of state; an excess tag is dropped and flagged
        if (head_v) begin
            if (cap_cnt_q == CW'(BURST_SIZE)) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned k = 0; k < BURST_SIZE; k++) begin
                    if (head_i == CW'(k)) begin
                        data_d[k*DATA_WIDTH +: DATA_WIDTH] = head_p ? '0 : ram_rdata;
                        mask_d[k] = head_p;
                    end
                end
                cap_cnt_d = cap_cnt_q + CW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_COLLECT;
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    patch_idx_d = '0;
                end
            end
            S_COLLECT: begin
                if (gen_done) begin
                    state_d = (cap_cnt_d == CW'(BURST_SIZE)) ? S_OUTPUT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cap_cnt_d == CW'(BURST_SIZE)) begin
                    state_d = S_OUTPUT;
                end else if ((issue_cnt_q < CW'(BURST_SIZE)) && (tv_d == '0)) begin
                    // Short patch: never-issued slots become unpadded zeros
                    state_d = S_OUTPUT;
                    err_d   = 1'b1;
                    for (int unsigned k = 0; k < BURST_SIZE; k++) begin
                        if (CW'(k) >= issue_cnt_q) begin
                            data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                            mask_d[k] = 1'b0;
                        end
                    end
                end
            end
            S_OUTPUT: begin
                if (patch_ready) begin
                    if (patch_idx_q == IW'(NUM_PATCHES - 1)) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                        patch_idx_d  = '0;
                    end else begin
                        state_d     = S_COLLECT;
                        patch_idx_d = patch_idx_q + IW'(1);
                        issue_cnt_d = '0;
                        cap_cnt_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        gen_enable_d  = (state_d == S_COLLECT);
        patch_valid_d = (state_d == S_OUTPUT);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            issue_cnt_q   <= '0;
            cap_cnt_q     <= '0;
            patch_idx_q   <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            gen_enable_q  <= 1'b0;
            patch_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            tv_q          <= '0;
            tp_q          <= '0;
            ti_q          <= '0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            cap_cnt_q     <= cap_cnt_d;
            patch_idx_q   <= patch_idx_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            frame_done_q  <= frame_done_d;
            gen_enable_q  <= gen_enable_d;
            patch_valid_q <= patch_valid_d;
            busy_q        <= busy_d;
            tv_q          <= tv_d;
            tp_q          <= tp_d;
            ti_q          <= ti_d;
        end
    end

    assign gen_enable     = gen_enable_q;
    assign patch_data     = data_q;
    assign patch_pad_mask = mask_q;
    assign patch_valid    = patch_valid_q;
    assign patch_idx      = patch_idx_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign err_overflow   = err_q;

endmodule

// File: tb/tb_patch_collect_conv.sv
// Bench for patch_collect_conv: unit 0 runs RAM_LATENCY=1 with a long frame,
// unit 1 runs RAM_LATENCY=3 with a 4-patch frame.
module tb_patch_collect_conv;

    logic             clk = 1'b0;
    logic [1:0]       rst;
    logic [1:0]       start;
    logic [1:0]       gen_enable;
    logic [1:0]       gen_valid;
    logic [1:0]       gen_zero_pad;
    logic [1:0]       gen_done;
    logic [1:0][7:0]  ram_rdata;
    logic [1:0][71:0] patch_data;
    logic [1:0][8:0]  patch_pad_mask;
    logic [1:0]       patch_valid;
    logic [1:0]       patch_ready;
    logic [1:0][9:0]  patch_idx;
    logic [1:0]       busy;
    logic [1:0]       frame_done;
    logic [1:0]       err_overflow;

    // RAM model: element k of the current patch reads back as ram_base + k
    logic [1:0][7:0]  ram_base;
    logic [1:0][7:0]  cur_k;
    logic [7:0]       rk [2][4];

    int n_pass = 0;
    int n_total = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    patch_collect_conv #(.RAM_LATENCY(1)) u0 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .gen_enable(gen_enable[0]),
        .gen_valid(gen_valid[0]), .gen_zero_pad(gen_zero_pad[0]), .gen_done(gen_done[0]),
        .ram_rdata(ram_rdata[0]), .patch_data(patch_data[0]), .patch_pad_mask(patch_pad_mask[0]),
        .patch_valid(patch_valid[0]), .patch_ready(patch_ready[0]), .patch_idx(patch_idx[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .err_overflow(err_overflow[0])
    );

    patch_collect_conv #(.RAM_LATENCY(3), .NUM_PATCHES(4)) u1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .gen_enable(gen_enable[1]),
        .gen_valid(gen_valid[1]), .gen_zero_pad(gen_zero_pad[1]), .gen_done(gen_done[1]),
        .ram_rdata(ram_rdata[1]), .patch_data(patch_data[1]), .patch_pad_mask(patch_pad_mask[1]),
        .patch_valid(patch_valid[1]), .patch_ready(patch_ready[1]), .patch_idx(patch_idx[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .err_overflow(err_overflow[1])
    );

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            rk[u][3] <= rk[u][2];
            rk[u][2] <= rk[u][1];
            rk[u][1] <= rk[u][0];
            rk[u][0] <= cur_k[u];
        end
    end
    assign ram_rdata[0] = 8'(ram_base[0] + rk[0][0]);
    assign ram_rdata[1] = 8'(ram_base[1] + rk[1][2]);

    always @(negedge clk) if (frame_done[1]) fd_cnt++;

    typedef struct {
        logic [8:0]  pads;
        int          n;
        bit          extra;
        logic [7:0]  base;
        logic [71:0] data;
        logic [8:0]  mask;
        int          lat;
        logic        err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic issue_patch(input int u, input logic [8:0] pads, input int n,
                               input bit extra, input logic [7:0] base);
        int w = 0;
        ram_base[u] = base;
        while (!gen_enable[u] && w < 50) begin tick(); w++; end
        chk("gen_enable_up", 128'(gen_enable[u]), 128'(1));
        for (int i = 0; i < n; i++) begin
            gen_valid[u]    = 1'b1;
            gen_zero_pad[u] = pads[i];
            cur_k[u]        = 8'(i);
            tick();
        end
        if (extra) begin
            gen_valid[u]    = 1'b1;
            gen_zero_pad[u] = 1'b0;
            cur_k[u]        = 8'(9);
            tick();
        end
        gen_valid[u]    = 1'b0;
        gen_zero_pad[u] = 1'b0;
        gen_done[u]     = 1'b1;
        tick();
        gen_done[u]     = 1'b0;
    endtask

    task automatic wait_valid(input int u, output int cycles);
        cycles = 0;
        while (!patch_valid[u] && cycles < 30) begin tick(); cycles++; end
        chk("patch_valid_timeout", 128'(patch_valid[u]), 128'(1));
    endtask

    task automatic start_frame(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        chk("gen_enable_after_start", 128'({gen_enable[u], busy[u]}), 128'(2'b11));
    endtask

    initial begin
        vec_t vecs[4];
        int lat;
        int bad;
        int hs;
        logic [71:0] exp_d;
        logic [71:0] got_d;
        logic [9:0]  got_i;

        vecs[0] = '{9'b000000000, 9, 1'b0, 8'h0A, 72'h12_11_10_0F_0E_0D_0C_0B_0A, 9'b000000000, 0, 1'b0};
        vecs[1] = '{9'b001001111, 9, 1'b0, 8'h0A, 72'h12_11_00_0F_0E_00_00_00_00, 9'b001001111, 0, 1'b0};
        vecs[2] = '{9'b000000000, 9, 1'b1, 8'h20, 72'h28_27_26_25_24_23_22_21_20, 9'b000000000, 0, 1'b0};
        vecs[3] = '{9'b000000000, 7, 1'b0, 8'h30, 72'h00_00_36_35_34_33_32_31_30, 9'b000000000, 1, 1'b1};

        rst = 2'b11; start = '0; gen_valid = '0; gen_zero_pad = '0; gen_done = '0;
        patch_ready = '0; ram_base = '0; cur_k = '0;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            chk("reset_outputs", 128'({gen_enable[u], patch_valid[u], busy[u], frame_done[u],
                 err_overflow[u], patch_idx[u], patch_pad_mask[u], patch_data[u]}), 128'(0));
        end
        rst = 2'b00;
        tick();

        // Unit 0: backpressure on patch 0
        start_frame(0);
        issue_patch(0, 9'h0, 9, 1'b0, 8'h0A);
        chk("bp_valid_after_done", 128'({patch_valid[0], gen_enable[0]}), 128'(2'b10));
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if ({patch_valid[0], gen_enable[0], patch_idx[0], patch_pad_mask[0], patch_data[0]} !==
                {1'b1, 1'b0, 10'd0, 9'd0, vecs[0].data}) bad++;
            tick();
        end
        chk("bp_stable_cycles_bad", 128'(bad), 128'(0));
        patch_ready[0] = 1'b1;
        tick();
        patch_ready[0] = 1'b0;
        chk("bp_release", 128'({gen_enable[0], patch_valid[0], patch_idx[0]}), 128'({1'b1, 1'b0, 10'd1}));

        // Unit 0: table of patch contents, indices 1..4
        for (int i = 0; i < 4; i++) begin
            issue_patch(0, vecs[i].pads, vecs[i].n, vecs[i].extra, vecs[i].base);
            chk("gen_enable_low_after_done", 128'(gen_enable[0]), 128'(0));
            wait_valid(0, lat);
            chk("valid_latency", 128'(lat), 128'(vecs[i].lat));
            chk("patch_data", 128'(patch_data[0]), 128'(vecs[i].data));
            chk("patch_pad_mask", 128'(patch_pad_mask[0]), 128'(vecs[i].mask));
            chk("patch_idx", 128'(patch_idx[0]), 128'(i + 1));
            chk("err_overflow", 128'(err_overflow[0]), 128'(vecs[i].err));
            patch_ready[0] = 1'b1;
            tick();
            patch_ready[0] = 1'b0;
        end

        // Unit 1: full 4-patch frame with random ready
        start_frame(1);
        hs = 0;
        for (int p = 0; p < 4; p++) begin
            issue_patch(1, 9'h0, 9, 1'b0, 8'(8'h40 + 16 * p));
            wait_valid(1, lat);
            for (int k = 0; k < 9; k++) exp_d[k*8 +: 8] = 8'(8'h40 + 16 * p + k);
            got_d = '0;
            got_i = '1;
            for (int c = 0; c < 100; c++) begin
                patch_ready[1] = 1'($urandom_range(0, 1));
                if (c == 99) patch_ready[1] = 1'b1;
                if (patch_valid[1] && patch_ready[1]) begin
                    got_d = patch_data[1];
                    got_i = patch_idx[1];
                    hs++;
                    tick();
                    break;
                end
                tick();
            end
            patch_ready[1] = 1'b0;
            chk("frame_patch_idx", 128'(got_i), 128'(p));
            chk("frame_patch_data", 128'(got_d), 128'(exp_d));
        end
        chk("frame_done_pulse", 128'({frame_done[1], busy[1], patch_valid[1], gen_enable[1]}), 128'(4'b1000));
        tick();
        chk("frame_done_end", 128'({frame_done[1], busy[1], err_overflow[1]}), 128'(0));
        chk("frame_counts", 128'({hs[7:0], fd_cnt[7:0]}), 128'({8'd4, 8'd1}));

        // Unit 1: reset while DRAIN holds in-flight tags, then a clean frame
        start_frame(1);
        issue_patch(1, 9'h0, 9, 1'b0, 8'h60);
        chk("drain_before_reset", 128'({busy[1], patch_valid[1], gen_enable[1]}), 128'(3'b100));
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("midframe_reset_outputs", 128'({gen_enable[1], patch_valid[1], busy[1], frame_done[1],
             err_overflow[1], patch_idx[1], patch_pad_mask[1], patch_data[1]}), 128'(0));
        tick();
        start_frame(1);
        issue_patch(1, 9'h0, 9, 1'b0, 8'h70);
        wait_valid(1, lat);
        chk("post_reset_data", 128'(patch_data[1]), 128'(72'h78_77_76_75_74_73_72_71_70));
        chk("post_reset_meta", 128'({patch_idx[1], patch_pad_mask[1], err_overflow[1]}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
